// File: rtl/AHB_package.sv
// Shared AHB bus types: burst encoding and transfer-type codes used by the
// master request controller and anything that drives its command port.
package AHB_package;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/ahb_master_req_ctrl.sv
// Master-side request stage: decodes a command to a slave arbiter, requests it,
// walks the burst beats on grant and reports done/error. Optional grant-wait
// timeout is enabled by defining AHB_REQ_TIMEOUT_EN.
module ahb_master_req_ctrl
    import AHB_package::*;
#(
    parameter int SLAVE_NUM   = 8,
    parameter int ADDR_W      = 32,
    parameter int SLV_IDX_W   = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  hburst_type           cmd_burst,
    input  logic                 cmd_write,
    output logic [SLAVE_NUM-1:0] hreq,
    input  logic [SLAVE_NUM-1:0] hgrant,
    output logic [ADDR_W-1:0]    haddr,
    output logic [1:0]           htrans,
    output hburst_type           hburst,
    output logic                 hwrite,
    output logic                 cmd_done,
    output logic                 cmd_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_XFER = 2'b10
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_ready;
    logic [SLAVE_NUM-1:0]   r_req, w_req_nxt, w_onehot;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
    logic [1:0]             r_trans, w_trans_nxt;
    hburst_type             r_burst, w_burst_nxt;
    logic                   r_write, w_write_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_err, w_err_nxt;
    logic [SLV_IDX_W-1:0]   r_idx, w_idx_nxt, w_cmd_idx;
    logic [4:0]             r_beats, w_beats_nxt;
    logic                   w_dec_err, w_grant, w_accept;

`ifdef AHB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
`else
    logic                   w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

    function automatic logic [4:0] f_beats(input hburst_type b);
        case (b)
            WRAP4, INCR4:   f_beats = 5'd4;
            WRAP8, INCR8:   f_beats = 5'd8;
            WRAP16, INCR16: f_beats = 5'd16;
            default:        f_beats = 5'd1;
        endcase
    endfunction

    // Wrapping bursts keep the upper bits and let only the block-offset bits roll over.
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                      input hburst_type        b);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = a + ADDR_W'(4);
        mask = '0;
        case (b)
            WRAP4:   mask = ADDR_W'(15);
            WRAP8:   mask = ADDR_W'(31);
            WRAP16:  mask = ADDR_W'(63);
            default: mask = '0;
        endcase
        if (mask != '0) begin
            f_next_addr = (a & ~mask) | (inc & mask);
        end else begin
            f_next_addr = inc;
        end
    endfunction

    assign w_cmd_idx = cmd_addr[ADDR_W-1 -: SLV_IDX_W];
    assign w_dec_err = (int'(w_cmd_idx) >= SLAVE_NUM);
    assign w_accept  = cmd_valid & r_ready;
    assign w_grant   = hgrant[r_idx];

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (w_cmd_idx == SLV_IDX_W'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_trans_nxt = r_trans;
        w_burst_nxt = r_burst;
        w_write_nxt = r_write;
        w_idx_nxt   = r_idx;
        w_beats_nxt = r_beats;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef AHB_REQ_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_dec_err) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_req_nxt   = w_onehot;
                        w_addr_nxt  = cmd_addr;
                        w_burst_nxt = cmd_burst;
                        w_write_nxt = cmd_write;
                        w_idx_nxt   = w_cmd_idx;
                        w_beats_nxt = f_beats(cmd_burst);
                        w_trans_nxt = HTRANS_IDLE;
`ifdef AHB_REQ_TIMEOUT_EN
                        w_cnt_nxt   = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                // A grant seen in the same cycle as the timeout still wins.
                if (w_grant) begin
                    w_state_nxt = S_XFER;
                    w_trans_nxt = HTRANS_NONSEQ;
                    if (r_beats == 5'd1) begin
                        w_req_nxt = '0;
                    end
`ifdef AHB_REQ_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
                end
            end
            S_XFER: begin
                if (w_grant) begin
                    if (r_beats == 5'd1) begin
                        w_state_nxt = S_IDLE;
                        w_trans_nxt = HTRANS_IDLE;
                        w_req_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt  = f_next_addr(r_addr, r_burst);
                        w_trans_nxt = HTRANS_SEQ;
                        w_beats_nxt = r_beats - 5'd1;
                        // Drop the request as the final beat goes out.
                        if (r_beats == 5'd2) begin
                            w_req_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = '0;
                w_trans_nxt = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_req   <= '0;
            r_addr  <= '0;
            r_trans <= HTRANS_IDLE;
            r_burst <= SINGLE;
            r_write <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_beats <= '0;
`ifdef AHB_REQ_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_trans <= w_trans_nxt;
            r_burst <= w_burst_nxt;
            r_write <= w_write_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_idx   <= w_idx_nxt;
            r_beats <= w_beats_nxt;
`ifdef AHB_REQ_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign cmd_ready = r_ready;
    assign hreq      = r_req;
    assign haddr     = r_addr;
    assign htrans    = r_trans;
    assign hburst    = r_burst;
    assign hwrite    = r_write;
    assign cmd_done  = r_done;
    assign cmd_err   = r_err;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Randomized self-checking bench for ahb_master_req_ctrl: an 8-slave instance
// for transfers and a 6-slave instance for address-decode errors.
module tb_ahb_master_req_ctrl;
    import AHB_package::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'h0;
    hburst_type  cmd_burst = SINGLE;
    logic        cmd_write = 1'b0;
    logic [7:0]  hreq;
    logic [7:0]  hgrant = 8'h0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    hburst_type  hburst;
    logic        hwrite, cmd_done, cmd_err;

    logic        c6_valid = 1'b0;
    logic        c6_ready;
    logic [31:0] c6_addr = 32'h0;
    hburst_type  c6_burst = SINGLE;
    logic        c6_write = 1'b0;
    logic [5:0]  h6_req;
    logic [5:0]  g6 = 6'h0;
    logic [31:0] h6_addr;
    logic [1:0]  h6_trans;
    hburst_type  h6_burst;
    logic        h6_write, c6_done, c6_err;

    int checks = 0;
    int errors = 0;

    ahb_master_req_ctrl #(.SLAVE_NUM(8), .ADDR_W(32), .SLV_IDX_W(3), .TIMEOUT_CYC(64)) u_dut (
        .hclk(clk), .hreset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_write(cmd_write),
        .hreq(hreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans), .hburst(hburst),
        .hwrite(hwrite), .cmd_done(cmd_done), .cmd_err(cmd_err)
    );

    ahb_master_req_ctrl #(.SLAVE_NUM(6), .ADDR_W(32), .SLV_IDX_W(3), .TIMEOUT_CYC(64)) u_dut6 (
        .hclk(clk), .hreset_n(rst_n), .cmd_valid(c6_valid), .cmd_ready(c6_ready),
        .cmd_addr(c6_addr), .cmd_burst(c6_burst), .cmd_write(c6_write),
        .hreq(h6_req), .hgrant(g6), .haddr(h6_addr), .htrans(h6_trans), .hburst(h6_burst),
        .hwrite(h6_write), .cmd_done(c6_done), .cmd_err(c6_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int f_beats(input hburst_type b);
        if (b == WRAP4 || b == INCR4) return 4;
        if (b == WRAP8 || b == INCR8) return 8;
        if (b == WRAP16 || b == INCR16) return 16;
        return 1;
    endfunction

    // Beat k address: wrapping bursts stay inside the 4*beats aligned block.
    function automatic logic [31:0] f_exp_addr(input logic [31:0] start, input hburst_type b, input int k);
        logic [31:0] size, base;
        size = 32'(4 * f_beats(b));
        if (b == WRAP4 || b == WRAP8 || b == WRAP16) begin
            base = start - (start % size);
            return base + ((start - base + 32'(4 * k)) % size);
        end
        return start + 32'(4 * k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and walks it to completion (or to beat abort_at).
    task automatic run_cmd(input logic [31:0] addr, input hburst_type b, input logic wr,
                           input int gdelay, input int stall_pct, input logic [15:0] stall_mask,
                           input int abort_at);
        logic [7:0]  oh;
        logic [31:0] ea;
        int n, k, guard;
        bit stall, used;
        oh = 8'(1) << addr[31:29];
        n = f_beats(b);
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_addr = addr; cmd_burst = b; cmd_write = wr;
        hgrant = 8'($urandom) & ~oh;
        step();
        cmd_valid = 1'b0; cmd_addr = $urandom;
        for (int i = 0; i <= gdelay; i++) begin
            checks++;
            if ({hreq, htrans, cmd_ready, cmd_done, cmd_err} !== {oh, 2'b00, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL req_phase cyc%0d: hreq=%h htrans=%b rdy=%b done=%b err=%b required hreq=%h htrans=00 rdy=0 done=0 err=0",
                         i, hreq, htrans, cmd_ready, cmd_done, cmd_err, oh);
            end
            hgrant = (i == gdelay) ? (8'($urandom) | oh) : (8'($urandom) & ~oh);
            step();
        end
        k = 0; used = 1'b0; guard = 0;
        while (k < n && guard < 400) begin
            ea = f_exp_addr(addr, b, k);
            checks++;
            if ({haddr, htrans, hreq, hburst, hwrite, cmd_done, cmd_err} !==
                {ea, (k == 0) ? 2'b10 : 2'b11, (k == n - 1) ? 8'h00 : oh, b, wr, 2'b00}) begin
                errors++;
                $display("FAIL beat%0d: haddr=%h htrans=%b hreq=%h hburst=%0d hwrite=%b done=%b err=%b required haddr=%h htrans=%b hreq=%h hburst=%0d hwrite=%b done=0 err=0",
                         k, haddr, htrans, hreq, hburst, hwrite, cmd_done, cmd_err,
                         ea, (k == 0) ? 2'b10 : 2'b11, (k == n - 1) ? 8'h00 : oh, b, wr);
            end
            if (k == abort_at) return;
            stall = (stall_mask[k] && !used) || ($urandom_range(99) < stall_pct);
            hgrant = stall ? (8'($urandom) & ~oh) : (8'($urandom) | oh);
            step();
            guard++;
            if (stall) used = 1'b1;
            else begin
                k++;
                used = 1'b0;
            end
        end
        hgrant = 8'($urandom);
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL beat_budget: beats completed=%0d required %0d", k, n);
        end
        checks++;
        if ({cmd_done, cmd_err, htrans, hreq, cmd_ready} !== {1'b1, 1'b0, 2'b00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL completion: done=%b err=%b htrans=%b hreq=%h rdy=%b required done=1 err=0 htrans=00 hreq=00 rdy=1",
                     cmd_done, cmd_err, htrans, hreq, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_addr = 32'h2000_0000; hgrant = 8'hFF;
        step();
        step();
        checks++;
        if ({hreq, haddr, htrans, hburst, hwrite, cmd_done, cmd_err, cmd_ready} !==
            {8'h00, 32'h0, 2'b00, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: hreq=%h haddr=%h htrans=%b hburst=%0d hwrite=%b done=%b err=%b rdy=%b required all zero",
                     hreq, haddr, htrans, hburst, hwrite, cmd_done, cmd_err, cmd_ready);
        end
        cmd_valid = 1'b0; hgrant = 8'h00; rst_n = 1'b1;
        step();
        checks++;
        if ({cmd_ready, hreq, htrans, c6_ready, h6_req} !== {1'b1, 8'h00, 2'b00, 1'b1, 6'h00}) begin
            errors++;
            $display("FAIL reset_release: rdy=%b hreq=%h htrans=%b rdy6=%b hreq6=%h required rdy=1 hreq=00 htrans=00 rdy6=1 hreq6=00",
                     cmd_ready, hreq, htrans, c6_ready, h6_req);
        end
    endtask

    task automatic test_idle_grant();
        for (int i = 0; i < 4; i++) begin
            hgrant = 8'($urandom) | 8'h01;
            step();
            checks++;
            if ({hreq, htrans, cmd_done, cmd_err, cmd_ready} !== {8'h00, 2'b00, 3'b001}) begin
                errors++;
                $display("FAIL idle_grant: hreq=%h htrans=%b done=%b err=%b rdy=%b required 00/00/0/0/1",
                         hreq, htrans, cmd_done, cmd_err, cmd_ready);
            end
        end
        hgrant = 8'h00;
    endtask

    task automatic test_single();
        run_cmd(32'h4000_0010, SINGLE, 1'b1, 3, 0, 16'h0, -1);
        step();
        checks++;
        if ({cmd_done, cmd_ready, hreq} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b rdy=%b hreq=%h required done=0 rdy=1 hreq=00", cmd_done, cmd_ready, hreq);
        end
    endtask

    task automatic test_incr4_stall();
        run_cmd(32'h2000_0000, INCR4, 1'b0, 1, 0, 16'h0002, -1);
    endtask

    task automatic test_wrap();
        run_cmd(32'h0000_0018, WRAP8, 1'b1, 0, 0, 16'h0, -1);
        run_cmd(32'h0000_0038, WRAP4, 1'b0, 2, 0, 16'h0, -1);
        run_cmd(32'hE000_0074, WRAP16, 1'b1, 1, 20, 16'h0, -1);
    endtask

    task automatic test_decode_err();
        c6_valid = 1'b1; c6_addr = 32'hE000_0000; c6_burst = INCR4; c6_write = 1'b1; g6 = 6'h3F;
        step();
        c6_valid = 1'b0;
        checks++;
        if ({c6_err, c6_done, h6_req, c6_ready} !== {1'b1, 1'b0, 6'h00, 1'b1}) begin
            errors++;
            $display("FAIL decode_err_idx7: err=%b done=%b hreq=%h rdy=%b required err=1 done=0 hreq=00 rdy=1", c6_err, c6_done, h6_req, c6_ready);
        end
        step();
        checks++;
        if ({c6_err, h6_req, c6_ready, h6_trans} !== {1'b0, 6'h00, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL decode_err_after: err=%b hreq=%h rdy=%b htrans=%b required err=0 hreq=00 rdy=1 htrans=00", c6_err, h6_req, c6_ready, h6_trans);
        end
        c6_valid = 1'b1; c6_addr = 32'hC000_0004;
        step();
        c6_valid = 1'b0;
        checks++;
        if ({c6_err, h6_req} !== {1'b1, 6'h00}) begin
            errors++;
            $display("FAIL decode_err_idx6: err=%b hreq=%h required err=1 hreq=00", c6_err, h6_req);
        end
        g6 = 6'h00;
        step();
        c6_valid = 1'b1; c6_addr = 32'hA000_0008; c6_burst = SINGLE; c6_write = 1'b0;
        step();
        c6_valid = 1'b0;
        checks++;
        if ({c6_err, h6_req, c6_ready} !== {1'b0, 6'h20, 1'b0}) begin
            errors++;
            $display("FAIL idx5_request: err=%b hreq=%h rdy=%b required err=0 hreq=20 rdy=0", c6_err, h6_req, c6_ready);
        end
        g6 = 6'h20;
        step();
        checks++;
        if ({h6_trans, h6_addr, h6_req, h6_burst, h6_write} !== {2'b10, 32'hA000_0008, 6'h00, SINGLE, 1'b0}) begin
            errors++;
            $display("FAIL idx5_beat: htrans=%b haddr=%h hreq=%h hburst=%0d hwrite=%b required 10/A0000008/00/0/0",
                     h6_trans, h6_addr, h6_req, h6_burst, h6_write);
        end
        step();
        g6 = 6'h00;
        checks++;
        if ({c6_done, c6_ready, h6_trans} !== {1'b1, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL idx5_done: done=%b rdy=%b htrans=%b required done=1 rdy=1 htrans=00", c6_done, c6_ready, h6_trans);
        end
    endtask

    task automatic test_reset_mid();
        run_cmd(32'h6000_0100, INCR16, 1'b1, 1, 0, 16'h0, 4);
        rst_n = 1'b0;
        step();
        checks++;
        if ({hreq, htrans, cmd_done, cmd_err, cmd_ready, haddr} !== {8'h00, 2'b00, 3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: hreq=%h htrans=%b done=%b err=%b rdy=%b haddr=%h required 00/00/0/0/0/0",
                     hreq, htrans, cmd_done, cmd_err, cmd_ready, haddr);
        end
        rst_n = 1'b1; hgrant = 8'h00;
        step();
        checks++;
        if ({cmd_ready, cmd_done, hreq} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_release: rdy=%b done=%b hreq=%h required rdy=1 done=0 hreq=00", cmd_ready, cmd_done, hreq);
        end
        run_cmd(32'h8000_0040, INCR8, 1'b0, 0, 25, 16'h0, -1);
    endtask

    task automatic test_back_to_back();
        run_cmd(32'h0000_0400, INCR4, 1'b1, 0, 0, 16'h0, -1);
        run_cmd(32'h2000_0800, SINGLE, 1'b0, 0, 0, 16'h0, -1);
        run_cmd(32'hE000_0FF0, INCR8, 1'b1, 0, 0, 16'h0, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        hburst_type  b;
        for (int t = 0; t < 25; t++) begin
            a = {3'($urandom_range(0, 7)), 27'($urandom), 2'b00};
            b = hburst_type'($urandom_range(0, 7));
            run_cmd(a, b, 1'($urandom), $urandom_range(0, 4), 30, 16'($urandom), -1);
        end
    endtask

    task automatic test_timeout();
`ifdef AHB_REQ_TIMEOUT_EN
        logic [7:0] oh;
        oh = 8'h08;
        cmd_valid = 1'b1; cmd_addr = 32'h6000_0000; cmd_burst = INCR4; cmd_write = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            hgrant = 8'($urandom) & ~oh;
            step();
            checks++;
            if (n < 64) begin
                if ({hreq, cmd_err} !== {oh, 1'b0}) begin
                    errors++;
                    $display("FAIL timeout_wait cyc%0d: hreq=%h err=%b required hreq=%h err=0", n, hreq, cmd_err, oh);
                end
            end else if ({hreq, cmd_err, cmd_ready, cmd_done} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL timeout_fire: hreq=%h err=%b rdy=%b done=%b required hreq=00 err=1 rdy=1 done=0", hreq, cmd_err, cmd_ready, cmd_done);
            end
        end
        hgrant = 8'h00;
        step();
`else
        run_cmd(32'h6000_0000, INCR4, 1'b0, 100, 0, 16'h0, -1);
`endif
    endtask

    initial begin
        test_reset();
        test_idle_grant();
        test_single();
        test_incr4_stall();
        test_wrap();
        test_decode_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
